alu_arbiter: RTL

//   Shares one registered ALU (ADD/SUB/NOT/AND/OR/XOR) between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 57 +++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/alu_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, op width and the registered flag bundle.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  // Codes 6 and 7 are reserved and produce a zero result.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_e;

  // Flags stored alongside each result when ALU_FLAGS_EN is defined.
  typedef struct packed {
    logic zero;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between client units and the shared ALU.
// Optional flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*3-1:0]          req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
`ifdef ALU_FLAGS_EN
  logic                          rsp_zero;
  logic                          rsp_carry;
`endif

  // Client side.
  modport master (
`ifdef ALU_FLAGS_EN
    input  rsp_zero,
    input  rsp_carry,
`endif
    output req_valid,
    input  req_ready,
    output req_op,
    output req_a,
    output req_b,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id,
    input  rsp_data
  );

  // ALU side.
  modport slave (
`ifdef ALU_FLAGS_EN
    output rsp_zero,
    output rsp_carry,
`endif
    input  req_valid,
    output req_ready,
    input  req_op,
    input  req_a,
    input  req_b,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id,
    output rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr and ascends with wrap.
// The pointer moves past the winner only when advance is high and a request exists.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] idx;
  logic            found;

  // Pick the first valid index at or after rr_ptr and precompute the pointer after it.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    idx      = '0;
    ptr_next = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = ID_W'((32'(idx) + 1) % NUM_REQ);
      end
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else if (advance && found) begin
      rr_ptr_q <= ptr_next;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shared registered ALU with round-robin arbitration and a single tagged result slot.
// Optional macro ALU_FLAGS_EN adds registered zero/carry flags.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
) (
  input logic           clk,
  input logic           resetn,
  alu_arbiter_if.slave  bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_W-1:0]       id;
`ifdef ALU_FLAGS_EN
    alu_flags_t            flags;
`endif
  } rsp_t;

  logic [0:0]            state_q;
  rsp_t                  rsp_q;
  rsp_t                  rsp_d;
  logic                  advance;
  logic                  grant;
  logic [NUM_REQ-1:0]    gnt;
  logic [ALU_OP_W-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [ID_W-1:0]       id_sel;

  // The slot can take a new op when empty, or when its result leaves this cycle.
  assign advance       = resetn && ((state_q == StEmpty) || bus.rsp_ready);
  assign grant         = advance && (|bus.req_valid);
  assign bus.req_ready = advance ? gnt : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .resetn  (resetn),
    .req     (bus.req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  // Route the granted requester's operands to the ALU.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    id_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_sel = bus.req_op[i*ALU_OP_W +: ALU_OP_W];
        a_sel  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
        id_sel = ID_W'(i);
      end
    end
  end

  // ALU op mux; reserved codes fall to the zero default.
  always_comb begin
    rsp_d    = '0;
    rsp_d.id = id_sel;
    unique case (op_sel)
`ifdef ALU_FLAGS_EN
      ALU_ADD: {rsp_d.flags.carry, rsp_d.data} = {1'b0, a_sel} + {1'b0, b_sel};
      ALU_SUB: begin
        rsp_d.data        = a_sel - b_sel;
        rsp_d.flags.carry = (a_sel < b_sel);
      end
`else
      ALU_ADD: rsp_d.data = a_sel + b_sel;
      ALU_SUB: rsp_d.data = a_sel - b_sel;
`endif
      ALU_NOT: rsp_d.data = ~a_sel;
      ALU_AND: rsp_d.data = a_sel & b_sel;
      ALU_OR:  rsp_d.data = a_sel | b_sel;
      ALU_XOR: rsp_d.data = a_sel ^ b_sel;
      default: rsp_d.data = '0;
    endcase
`ifdef ALU_FLAGS_EN
    rsp_d.flags.zero = (rsp_d.data == '0);
`endif
  end

  // Slot state and result register; a held result is dropped on reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StEmpty;
      rsp_q   <= '0;
    end else if (grant) begin
      state_q <= StFull;
      rsp_q   <= rsp_d;
    end else if (bus.rsp_ready) begin
      state_q <= StEmpty;
    end
  end

  assign bus.rsp_valid = (state_q == StFull);
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_data  = rsp_q.data;
`ifdef ALU_FLAGS_EN
  assign bus.rsp_zero  = rsp_q.flags.zero;
  assign bus.rsp_carry = rsp_q.flags.carry;
`endif

endmodule
